// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment glyph table, result type and FSM states
package seg7_pkg;

  // Active-low segments, bit6=a .. bit0=g. Index = displayed value (0..9, A,b,C,d,E,F).
  localparam logic [6:0] SEG7_GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  typedef struct packed {
    logic [3:0] value;
    logic       is_hex;
    logic       blank;
    logic       err;
  } seg7_result_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } seg7_state_e;

  // Forward mapping used by the display encoder side.
  function automatic logic [6:0] seg7_encode(input logic [3:0] v);
    return SEG7_GLYPH[v];
  endfunction

endpackage

// File: rtl/seg7_glyph_lookup.sv
// rtl/seg7_glyph_lookup.sv - combinational reverse lookup of one 7-segment pattern
module seg7_glyph_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] value_o,
  output logic       is_letter_o,
  output logic       is_blank_o,
  output logic       legal_o
);

  // Match the pattern against every glyph; blank is legal but carries value 0.
  always_comb begin
    value_o     = 4'd0;
    is_letter_o = 1'b0;
    is_blank_o  = (seg_i == SEG7_BLANK);
    legal_o     = (seg_i == SEG7_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG7_GLYPH[i]) begin
        value_o     = 4'(i);
        is_letter_o = (i >= 10);
        legal_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_readback_decoder.sv
// rtl/seg7_readback_decoder.sv - debounced two-digit 7-segment readback with valid/ready result
module seg7_readback_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4  // legal 1..15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] value,
  output logic       is_hex,
  output logic       blank,
  output logic       err,
  output logic       overrun
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

  logic [6:0]   smp0_q, smp1_q;
  logic [13:0]  last_q;
  logic [3:0]   cnt_q, cnt_d;
  seg7_state_e  state_q, state_d;
  seg7_result_t res_q, res_d, dec_res;
  logic         overrun_q, overrun_d;
  logic         decode_fire;

  logic [3:0] lo_value, hi_value;
  logic       lo_letter, hi_letter;
  logic       lo_blank, hi_blank;
  logic       lo_legal, hi_legal;

  seg7_glyph_lookup u_lookup_lo (
    .seg_i       (smp0_q),
    .value_o     (lo_value),
    .is_letter_o (lo_letter),
    .is_blank_o  (lo_blank),
    .legal_o     (lo_legal)
  );

  seg7_glyph_lookup u_lookup_hi (
    .seg_i       (smp1_q),
    .value_o     (hi_value),
    .is_letter_o (hi_letter),
    .is_blank_o  (hi_blank),
    .legal_o     (hi_legal)
  );

  // Run length of identical samples, saturating so a long hold never wraps.
  always_comb begin
    cnt_d = 4'd1;
    if ({seg1, seg0} == {smp1_q, smp0_q}) begin
      cnt_d = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 4'd1;
    end
  end

  // A stable pair is decoded once; repeating the same display yields nothing new.
  assign decode_fire = (cnt_q == STABLE_MAX) && ({smp1_q, smp0_q} != last_q);

  // Map the sampled pair to a number; anything not a legal display is an error.
  always_comb begin
    dec_res = '0;
    if (hi_blank && lo_blank) begin
      dec_res.blank = 1'b1;
    end else if (hi_blank && lo_legal) begin
      dec_res.value  = lo_value;
      dec_res.is_hex = lo_letter;
    end else if (hi_legal && !hi_blank && !hi_letter && (hi_value == 4'd1) &&
                 lo_legal && !lo_blank && !lo_letter && (lo_value <= 4'd5)) begin
      dec_res.value = 4'd10 + lo_value;
    end else begin
      dec_res.err = 1'b1;
    end
  end

  // Result handshake: new decodes overwrite a pending result, flagging overrun if unaccepted.
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    overrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (decode_fire) begin
          state_d = ST_PRESENT;
          res_d   = dec_res;
        end
      end
      ST_PRESENT: begin
        if (decode_fire) begin
          res_d     = dec_res;
          overrun_d = !out_ready;
        end else if (out_ready) begin
          state_d = ST_IDLE;
          res_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        res_d   = '0;
      end
    endcase
  end

  // Sample registers, stability counter, dedup memory and handshake state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      smp0_q    <= SEG7_BLANK;
      smp1_q    <= SEG7_BLANK;
      last_q    <= {SEG7_BLANK, SEG7_BLANK};
      cnt_q     <= 4'd0;
      state_q   <= ST_IDLE;
      res_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      smp0_q    <= seg0;
      smp1_q    <= seg1;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      res_q     <= res_d;
      overrun_q <= overrun_d;
      if (decode_fire) begin
        last_q <= {smp1_q, smp0_q};
      end
    end
  end

  assign out_valid = (state_q == ST_PRESENT);
  assign value     = res_q.value;
  assign is_hex    = res_q.is_hex;
  assign blank     = res_q.blank;
  assign err       = res_q.err;
  assign overrun   = overrun_q;

endmodule
